count_enable_gen: RTL and testbench
===================================

Name: count_enable_gen

Overview:
Conditions a raw, asynchronous, bouncy event input (pushbutton or sensor) into clean single-cycle count_enable pulses for the 4-bit synchronous counter stage. It sits directly upstream of that counter, and its count_enable output wires straight to the counter's count_enable input. It synchronizes, debounces and edge-detects the input. It can optionally auto-repeat while the input is held.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on raw_in (≥2)
DEBOUNCE_CYCLES, 4, consecutive stable synced samples needed to accept a level change (1..2**CNT_W)
REPEAT_CYCLES, 8, period in clocks between auto-repeat pulses while held (1..2**CNT_W)
CNT_W, 8, width of the internal debounce and repeat counters

Ports:
clock  input  1  single system clock; all flops on the rising edge
clear  input  1  synchronous active-low reset, sampled on the rising edge of clock
raw_in  input  1  asynchronous raw event level; active-high
mode  input  1  0 = one pulse per press, 1 = auto-repeat while held
run  input  1  gates count_enable; FSM keeps tracking when run = 0
count_enable  output  1  registered single-cycle pulse to the downstream counter
pressed  output  1  registered; high while the debounced input is high (HELD or RELEASE state)

Behaviour:
- Reset: clear = 0 at a rising edge forces the following:
  - all synchronizer flops and both counters to 0;
  - state to IDLE;
  - count_enable = 0 and pressed = 0 after that edge.
  - clear has priority over every other input.
- Synchronizer: s is the output of the last of SYNC_STAGES chained flops. raw_in is never used unsynchronized.
- FSM states: IDLE, ARM, HELD, RELEASE. The default case is IDLE.
  - IDLE: if s = 1, go to ARM with db_cnt = 0.
  - ARM:
    - if s = 0, go to IDLE; no pulse.
    - else if db_cnt = DEBOUNCE_CYCLES-1, go to HELD, set rpt_cnt = 0, pulse.
    - else db_cnt increments.
  - HELD:
    - if s = 0, go to RELEASE with db_cnt = 0.
    - else if mode = 1 and rpt_cnt = REPEAT_CYCLES-1, pulse and set rpt_cnt = 0.
    - else if mode = 1, rpt_cnt increments.
    - if mode = 0, rpt_cnt holds 0.
  - RELEASE:
    - if s = 1, go to HELD with rpt_cnt = 0; this is a glitch and produces no pulse.
    - else if db_cnt = DEBOUNCE_CYCLES-1, go to IDLE.
    - else db_cnt increments.
- Pulse: count_enable = run AND (pulse condition), registered on the same edge as the transition. It is high for exactly one clock and never high on two consecutive edges unless REPEAT_CYCLES = 1.
- Latency: raw_in is stable high before edge 0 → count_enable is high after edge SYNC_STAGES+DEBOUNCE_CYCLES+1 (7 with defaults).
- Glitch rejection: any synced high run shorter than DEBOUNCE_CYCLES samples produces no pulse.
- pressed is registered from the next state: 1 for HELD or RELEASE, else 0.
- Counters never wrap. They compare to the limit and reload, so the limits must be ≤ 2**CNT_W.
- mode change mid-hold takes effect on the next edge. Switching from 1 to 0 clears rpt_cnt.
- run = 0 suppresses pulses but not state or counters. A repeat boundary hit while run = 0 is lost and not deferred.
- Reset mid-operation: after clear returns high with raw_in still high, the press is treated as new. A pulse is issued SYNC_STAGES+DEBOUNCE_CYCLES+1 edges after the first edge with clear = 1.

Decomposition:
- Shared include file (Verilog-2001) holds the state encodings IDLE = 2'd0, ARM = 2'd1, HELD = 2'd2, RELEASE = 2'd3.
- One sub-module is natural: sync_chain, a parameterized SYNC_STAGES flop synchronizer with synchronous active-low clear, instantiated once.
- FSM, counters and output registers stay in count_enable_gen.

Test Plan:
- Reset: clear = 0 for 3 edges, raw_in = 1, mode = 1 → count_enable = 0, pressed = 0 throughout, state IDLE.
- Clean press, mode = 0, run = 1: raw_in 0→1 held 30 clocks → exactly one count_enable pulse, on edge 7 after the rise. pressed rises on that edge. After raw_in falls, pressed drops on edge 7 after the fall.
- Bounce: raw_in high 3 clocks, low 2, high 3, low → no pulse, pressed stays 0. Then high 10 clocks → a single pulse.
- Auto-repeat, mode = 1, raw_in held 40 clocks → pulses at edges 7, 15, 23, 31, 39. Drive the downstream counter from count_enable and check its count goes 0→5.
- run = 0 throughout a 20-clock press → no pulse, pressed behaves as in the clean-press case. Raise run mid-hold in mode = 1 → pulses resume on the next repeat boundary only.
- clear pulsed low for 1 clock while in HELD with raw_in high → pressed = 0 next edge, then a new pulse 7 edges after clear returns high.

Source files
------------

// File: rtl/count_enable_gen_pkg.sv
// Shared types for the count-enable conditioner.
// State encodings are fixed so waveforms read the same everywhere.
package count_enable_gen_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } ceg_state_e;

  function automatic logic is_pressed(input ceg_state_e st);
    return (st == HELD) || (st == RELEASE);
  endfunction

endpackage

// File: rtl/count_enable_gen_sync_chain.sv
// Multi-flop synchronizer for an asynchronous level.
// Synchronous active-low clear empties the whole chain.
module count_enable_gen_sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic clear,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clock) begin
    if (!clear) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/count_enable_gen.sv
// Synchronize, debounce and edge-detect a raw event into
// single-cycle count_enable pulses, with optional auto-repeat.
module count_enable_gen
  import count_enable_gen_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 8,
  parameter int CNT_W           = 8
) (
  input  logic clock,
  input  logic clear,
  input  logic raw_in,
  input  logic mode,
  input  logic run,
  output logic count_enable,
  output logic pressed
);

  localparam logic [CNT_W-1:0] DB_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_LAST =
    CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic             w_s;
  ceg_state_e       r_state;
  ceg_state_e       w_state_nx;
  logic [CNT_W-1:0] r_db;
  logic [CNT_W-1:0] w_db_nx;
  logic [CNT_W-1:0] r_rpt;
  logic [CNT_W-1:0] w_rpt_nx;
  logic             w_pulse;
  logic             r_ce;
  logic             r_pressed;

  count_enable_gen_sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clock (clock),
    .clear (clear),
    .i_d   (raw_in),
    .o_q   (w_s)
  );

  always_ff @(posedge clock) begin
    if (!clear) begin
      r_state   <= IDLE;
      r_db      <= '0;
      r_rpt     <= '0;
      r_ce      <= 1'b0;
      r_pressed <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_db      <= w_db_nx;
      r_rpt     <= w_rpt_nx;
      r_ce      <= run & w_pulse;
      r_pressed <= is_pressed(w_state_nx);
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_db_nx    = r_db;
    w_rpt_nx   = r_rpt;
    w_pulse    = 1'b0;
    case (r_state)
      ARM: begin
        if (!w_s) begin
          w_state_nx = IDLE;
        end else if (r_db == DB_LAST) begin
          w_state_nx = HELD;
          w_rpt_nx   = '0;
          w_pulse    = 1'b1;
        end else begin
          w_db_nx = r_db + ONE;
        end
      end
      HELD: begin
        if (!w_s) begin
          w_state_nx = RELEASE;
          w_db_nx    = '0;
        end else if (!mode) begin
          w_rpt_nx = '0;
        end else if (r_rpt == RPT_LAST) begin
          w_rpt_nx = '0;
          w_pulse  = 1'b1;
        end else begin
          w_rpt_nx = r_rpt + ONE;
        end
      end
      // A re-rise during release is bounce: resume holding silently.
      RELEASE: begin
        if (w_s) begin
          w_state_nx = HELD;
          w_rpt_nx   = '0;
        end else if (r_db == DB_LAST) begin
          w_state_nx = IDLE;
        end else begin
          w_db_nx = r_db + ONE;
        end
      end
      default: begin
        if (w_s) begin
          w_state_nx = ARM;
          w_db_nx    = '0;
        end
      end
    endcase
  end

  assign count_enable = r_ce;
  assign pressed      = r_pressed;

endmodule

// File: tb/tb_count_enable_gen.sv
// Directed bench for count_enable_gen with an expectation queue.
// Edge k is the k-th rising edge after an input change.
module tb_count_enable_gen;

  localparam int LAT = 7;
  localparam int PER = 8;

  typedef struct {
    logic ce;
    logic pr;
  } exp_t;

  logic clock = 1'b0;
  logic clear = 1'b0;
  logic raw_in = 1'b0;
  logic mode = 1'b0;
  logic run = 1'b0;
  logic count_enable;
  logic pressed;

  logic [3:0] r_cnt;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  count_enable_gen dut (
    .clock        (clock),
    .clear        (clear),
    .raw_in       (raw_in),
    .mode         (mode),
    .run          (run),
    .count_enable (count_enable),
    .pressed      (pressed)
  );

  always #5 clock = ~clock;

  // Downstream 4-bit counter fed by count_enable.
  always_ff @(posedge clock) begin
    if (!clear) r_cnt <= '0;
    else if (count_enable) r_cnt <= r_cnt + 4'd1;
  end

  task automatic step(input logic ce, input logic pr,
                      input string tag, input int k);
    exp_t e;
    e.ce = ce;
    e.pr = pr;
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    checks++;
    assert (count_enable === e.ce) else begin
      errors++;
      $error("FAIL %s ce edge %0d: got %b want %b",
             tag, k, count_enable, e.ce);
    end
    checks++;
    assert (pressed === e.pr) else begin
      errors++;
      $error("FAIL %s pressed edge %0d: got %b want %b",
             tag, k, pressed, e.pr);
    end
  endtask

  // Clean press from IDLE: raw high for hold edges, then low.
  // run is raised before edge ron+1 (ron = 0: from the start).
  task automatic press(input int hold, input int tail,
                       input logic md, input int ron,
                       input string tag);
    logic ce;
    logic pr;
    mode = md;
    run = (ron == 0);
    raw_in = 1'b1;
    for (int k = 1; k <= hold + tail; k++) begin
      if (k == ron + 1) run = 1'b1;
      if (k == hold + 1) raw_in = 1'b0;
      ce = (k > ron) && (k >= LAT) && (k <= hold + 2) &&
           (md ? ((k - LAT) % PER == 0) : (k == LAT));
      pr = (k >= LAT) && (k <= hold + LAT - 1);
      step(ce, pr, tag, k);
    end
  endtask

  initial begin
    // Reset with raw high and repeat mode selected.
    clear = 1'b0;
    raw_in = 1'b1;
    mode = 1'b1;
    run = 1'b1;
    for (int k = 1; k <= 3; k++) step(1'b0, 1'b0, "reset", k);
    raw_in = 1'b0;
    clear = 1'b1;
    for (int k = 1; k <= 4; k++) step(1'b0, 1'b0, "idle", k);

    checks++;
    assert (r_cnt === 4'd0) else begin
      errors++;
      $error("FAIL cnt_start: got %0d want 0", r_cnt);
    end
    press(40, 10, 1'b1, 0, "repeat");
    checks++;
    assert (r_cnt === 4'd5) else begin
      errors++;
      $error("FAIL cnt_repeat: got %0d want 5", r_cnt);
    end

    press(30, 10, 1'b0, 0, "clean");

    // Bounce: two short highs must not pass the debouncer.
    mode = 1'b0;
    run = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      raw_in = (k <= 3) || (k >= 6 && k <= 8);
      step(1'b0, 1'b0, "bounce", k);
    end
    press(10, 10, 1'b0, 0, "after_bounce");

    press(20, 10, 1'b0, 40, "run_off");
    press(30, 10, 1'b1, 10, "run_mid");

    // Clear pulse while held: press restarts from scratch.
    mode = 1'b0;
    run = 1'b1;
    raw_in = 1'b1;
    for (int k = 1; k <= 10; k++)
      step(k == LAT, k >= LAT, "pre_clear", k);
    clear = 1'b0;
    step(1'b0, 1'b0, "clear_edge", 11);
    clear = 1'b1;
    for (int k = 1; k <= 12; k++)
      step(k == LAT, k >= LAT, "post_clear", k);
    raw_in = 1'b0;
    for (int k = 1; k <= 10; k++)
      step(1'b0, k < LAT, "post_clear_rel", k);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_empty: got %0d want 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
